// File: rtl/serial_receiver.sv
// Serial word receiver: samples DataIn on rising edges of the transmit clock,
// assembles LENGTH-bit words MSB first and flags aborted frames.
module serial_receiver #(
    parameter int LENGTH = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              DataIn,
    input  logic              clkTxIn,
    input  logic              DinValid,
    output logic [LENGTH-1:0] dataOut,
    output logic              wordValid,
    output logic              frameError,
    output logic              rxBusy
);

    localparam int CW = $clog2(LENGTH + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [LENGTH-1:0] shift_q, shift_d;
    logic [LENGTH-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;
    logic              clk_tx_q, clk_tx_d;
    logic              armed_q, armed_d;
    logic              bit_edge;
    logic [LENGTH-1:0] shifted;

    // Edge detect, word assembly and frame FSM next-state logic.
    // armed_q blocks a false edge when clkTxIn is already high out of reset.
    always_comb begin
        clk_tx_d = clkTxIn;
        armed_d  = armed_q | ~clkTxIn;
        bit_edge = clkTxIn & ~clk_tx_q & armed_q;
        shifted  = {shift_q[LENGTH-2:0], DataIn};
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        ferr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bit_edge && DinValid) begin
                    shift_d = shifted;
                    cnt_d   = CW'(1);
                    state_d = RECV;
                end
            end
            RECV: begin
                if (!DinValid) begin
                    ferr_d  = 1'b1;
                    shift_d = '0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (bit_edge) begin
                    shift_d = shifted;
                    if (cnt_q == CW'(LENGTH - 1)) begin
                        data_d  = shifted;
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            clk_tx_q <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            clk_tx_q <= clk_tx_d;
            armed_q  <= armed_d;
        end
    end

    assign dataOut    = data_q;
    assign wordValid  = valid_q;
    assign frameError = ferr_q;
    assign rxBusy     = (state_q == RECV);

endmodule

// File: tb/tb_serial_receiver.sv
// Scoreboard bench for serial_receiver: stimulus queues expected words and
// frame errors, a monitor checks every output pulse against the queue.
module tb_serial_receiver;

    logic        clk = 1'b0;
    logic        reset;
    logic        DataIn;
    logic        clkTxIn;
    logic        DinValid;
    logic [15:0] dataOut;
    logic        wordValid;
    logic        frameError;
    logic        rxBusy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        bit          err;
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t exp_q[$];

    serial_receiver #(.LENGTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .DataIn     (DataIn),
        .clkTxIn    (clkTxIn),
        .DinValid   (DinValid),
        .dataOut    (dataOut),
        .wordValid  (wordValid),
        .frameError (frameError),
        .rxBusy     (rxBusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Send the top nbits of w MSB first; optionally queue the completed word.
    task automatic send_bits(input logic [15:0] w, input int nbits,
                             input int hi, input int lo,
                             input bit push, input bit chk_busy);
        exp_t e;
        for (int c = 1; c <= nbits; c++) begin
            DataIn  = w[16-c];
            clkTxIn = 1'b1;
            if (push && c == nbits) begin
                e.err  = 1'b0;
                e.data = w;
                e.at   = cyc + 1;
                exp_q.push_back(e);
            end
            tick(hi);
            if (chk_busy)
                check($sformatf("busy_bit%0d", c), 32'(rxBusy),
                      32'(c < 16));
            clkTxIn = 1'b0;
            tick(lo);
        end
    endtask

    // Monitor: every output pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (wordValid && frameError) begin
                total++;
                bad++;
                $display("FAIL both_pulses at cycle %0d", cyc);
            end
            if (wordValid || frameError) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected: wv=%b fe=%b data=%h cyc=%0d",
                             wordValid, frameError, dataOut, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (frameError !== e.err || dataOut !== e.data ||
                        cyc != e.at) begin
                        bad++;
                        $display("FAIL pulse: fe=%b data=%h cyc=%0d want fe=%b data=%h cyc=%0d",
                                 frameError, dataOut, cyc, e.err, e.data,
                                 e.at);
                    end
                end
            end
        end
    end

    initial begin
        exp_t e;
        reset    = 1'b1;
        DataIn   = 1'b0;
        clkTxIn  = 1'b0;
        DinValid = 1'b0;
        tick(3);
        check("rst_data", 32'(dataOut), 32'h0);
        check("rst_wv", 32'(wordValid), 32'h0);
        check("rst_fe", 32'(frameError), 32'h0);
        check("rst_busy", 32'(rxBusy), 32'h0);
        reset = 1'b0;
        tick(3);

        // Abort after 5 bits.
        DinValid = 1'b1;
        send_bits(16'hB000, 5, 4, 4, 1'b0, 1'b1);
        DinValid = 1'b0;
        e.err  = 1'b1;
        e.data = 16'h0000;
        e.at   = cyc + 1;
        exp_q.push_back(e);
        tick(3);
        check("ferr_busy", 32'(rxBusy), 32'h0);
        check("ferr_data", 32'(dataOut), 32'h0);

        // Single word, 4/4 divider.
        DinValid = 1'b1;
        send_bits(16'hA5C3, 16, 4, 4, 1'b1, 1'b1);
        DinValid = 1'b0;
        tick(3);
        check("a5c3_hold", 32'(dataOut), 32'hA5C3);

        // Back-to-back words with DinValid held high.
        DinValid = 1'b1;
        send_bits(16'h1234, 16, 4, 4, 1'b1, 1'b0);
        send_bits(16'hFFFF, 16, 4, 4, 1'b1, 1'b0);
        DinValid = 1'b0;
        tick(3);
        check("b2b_hold", 32'(dataOut), 32'hFFFF);

        // Edges without DinValid are ignored.
        send_bits(16'hFFFF, 16, 4, 4, 1'b0, 1'b0);
        send_bits(16'hF000, 4, 4, 4, 1'b0, 1'b0);
        check("novalid_busy", 32'(rxBusy), 32'h0);
        check("novalid_data", 32'(dataOut), 32'hFFFF);

        // Reset mid-word, released while clkTxIn is high.
        DinValid = 1'b1;
        send_bits(16'h0F0F, 9, 4, 4, 1'b0, 1'b1);
        reset = 1'b1;
        tick(2);
        check("rst2_busy", 32'(rxBusy), 32'h0);
        check("rst2_data", 32'(dataOut), 32'h0);
        clkTxIn = 1'b1;
        DataIn  = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(3);
        check("rst2_noedge", 32'(rxBusy), 32'h0);
        clkTxIn = 1'b0;
        tick(4);
        send_bits(16'hBEEF, 16, 4, 4, 1'b1, 1'b1);
        DinValid = 1'b0;
        tick(3);

        // Fastest divider, 1/1.
        DinValid = 1'b1;
        send_bits(16'h8001, 16, 1, 1, 1'b1, 1'b0);
        DinValid = 1'b0;
        tick(3);
        check("fast_hold", 32'(dataOut), 32'h8001);

        tick(5);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 Parameter: LENGTH, default 16, number of data bits per serial word (legal range 2..32).
REQ-002 clk  input  1  system clock, single clock domain; all logic updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 DataIn  input  1  serial data line, driven by the transmitter's DataOut, MSB first.
REQ-005 clkTxIn  input  1  divided transmit clock from the transmitter's clkTxOut; synchronous to clk.
REQ-006 DinValid  input  1  frame-valid qualifier from the transmitter's DoutValid; high for the whole word.
REQ-007 dataOut  output  LENGTH  last completely received word.
REQ-008 wordValid  output  1  one-cycle pulse; dataOut updated in the same cycle.
REQ-009 frameError  output  1  one-cycle pulse; word aborted before LENGTH bits.
REQ-010 rxBusy  output  1  high while a word is partially received.

Function
REQ-011 The block SHALL register clkTxIn once (clkTxIn_q); a bit edge is the cycle where clkTxIn=1 and clkTxIn_q=0.
REQ-012 clkTxIn high and low phases SHALL each be at least 1 clk cycle; no other divider ratio constraint.
REQ-013 On a bit edge with DinValid=1, DataIn SHALL be shifted into the LSB of a LENGTH-bit shift register (MSB first overall).
REQ-014 Bit edges with DinValid=0 SHALL be ignored; DataIn SHALL be ignored outside bit edges.
REQ-015 FSM states: IDLE, RECV.
REQ-016 IDLE: on a bit edge with DinValid=1, capture bit, bitCount=1, go to RECV; otherwise stay.
REQ-017 RECV: on each bit edge with DinValid=1, capture bit, bitCount+1.
REQ-018 RECV: on the capture making bitCount=LENGTH, the next cycle SHALL show dataOut=assembled word and wordValid=1 for exactly one cycle; state returns to IDLE, bitCount=0.
REQ-019 RECV: DinValid=0 before LENGTH bits captured SHALL give frameError=1 for one cycle next cycle, discard partial bits, return to IDLE, leave dataOut unchanged.
REQ-020 If DinValid stays high after a completed word, the next bit edge SHALL start a new word (back-to-back, no gap cycle needed).
REQ-021 wordValid and frameError SHALL never be high in the same cycle.
REQ-022 rxBusy SHALL equal (state==RECV), registered.
REQ-023 bitCount SHALL be wide enough for LENGTH and never wrap within a word.
REQ-024 dataOut SHALL hold its value between wordValid pulses.

Reset
REQ-025 While reset=1: state=IDLE, bitCount=0, shift register=0, dataOut=0, wordValid=0, frameError=0, rxBusy=0, clkTxIn_q=0.
REQ-026 Reset SHALL override all other inputs; a word in progress at reset is discarded with no frameError pulse.
REQ-027 After reset deasserts, if clkTxIn is already high, no bit edge is seen until clkTxIn goes low then high again.

Verification
REQ-028 LENGTH=16, clkTxIn period 8 clk (4 high/4 low), DinValid=1, send 16'hA5C3 MSB first -> wordValid one cycle after 16th bit edge, dataOut=16'hA5C3, rxBusy high bits 1..15.
REQ-029 Send 5 bits then DinValid=0 -> frameError one-cycle pulse next cycle, dataOut stays 16'h0000, rxBusy=0.
REQ-030 Back-to-back 16'h1234 then 16'hFFFF with DinValid held high -> two wordValid pulses, 16 bit edges apart, correct values each.
REQ-031 Toggle clkTxIn with DinValid=0 for 20 edges -> no wordValid, no frameError, rxBusy=0.
REQ-032 Reset asserted after 9 bits of 16'h0F0F, then full 16'hBEEF -> no pulse for the aborted word, wordValid with dataOut=16'hBEEF.
REQ-033 clkTxIn period 2 clk (1 high/1 low), send 16'h8001 -> dataOut=16'h8001, wordValid after 16th edge.
